// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM with March C- self-test: sequencer state
// encoding, read/write op encoding with data polarity, and the per-element
// op count, direction and ordering.
package sram_pkg;

   typedef enum logic [3:0] {
      IDLE,
      M0,      // ascending  w0
      M1,      // ascending  r0, w1
      M2,      // ascending  r1, w0
      M3,      // descending r0, w1
      M4,      // descending r1, w0
      M5,      // descending r0
      FLUSH,   // last compare of a passing run resolves here
      DONE     // abort landing state after a mismatch
   } march_state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_kind_e;

   // pol is the data background: expected value on a read, written value on a write
   typedef struct packed {
      op_kind_e kind;
      logic     pol;
   } march_op_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Number of ops each element performs at every address (0 outside the sweep)
   function automatic logic [1:0] elem_len(input march_state_e s);
      case (s)
         M0, M5:         elem_len = 2'd1;
         M1, M2, M3, M4: elem_len = 2'd2;
         default:        elem_len = 2'd0;
      endcase
   endfunction

   function automatic logic elem_dir(input march_state_e s);
      case (s)
         M3, M4, M5: elem_dir = DIR_DOWN;
         default:    elem_dir = DIR_UP;
      endcase
   endfunction

   // Op performed by element s at step 'phase' of the current address
   function automatic march_op_t elem_op(input march_state_e s, input logic phase);
      case (s)
         M0:      elem_op = '{kind: OP_WR, pol: 1'b0};
         M1, M3:  elem_op = phase ? '{kind: OP_WR, pol: 1'b1} : '{kind: OP_RD, pol: 1'b0};
         M2, M4:  elem_op = phase ? '{kind: OP_WR, pol: 1'b0} : '{kind: OP_RD, pol: 1'b1};
         M5:      elem_op = '{kind: OP_RD, pol: 1'b0};
         default: elem_op = '{kind: OP_RD, pol: 1'b0};
      endcase
   endfunction

   function automatic march_state_e elem_next(input march_state_e s);
      case (s)
         M0:      elem_next = M1;
         M1:      elem_next = M2;
         M2:      elem_next = M3;
         M3:      elem_next = M4;
         M4:      elem_next = M5;
         M5:      elem_next = FLUSH;
         default: elem_next = IDLE;
      endcase
   endfunction

endpackage

// File: rtl/sram_march_fsm.sv
// March C- sequencer: steps elements and addresses, issues one array op per
// cycle, compares read data one cycle after it is registered and captures
// the first failing address. Only built when SRAM_BIST_EN is defined.
`ifdef SRAM_BIST_EN
module sram_march_fsm
   import sram_pkg::*;
#(
   parameter int MEM_DEPTH  = 8192,
   parameter int DATA_WIDTH = 32,
   parameter int BITW       = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bist_start,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  arr_en,
   output logic                  arr_we,
   output logic [BITW-1:0]       arr_addr,
   output logic [DATA_WIDTH-1:0] arr_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [BITW-1:0]       fail_addr
);

   localparam logic [BITW-1:0] LAST_ADDR = BITW'(MEM_DEPTH - 1);

   march_state_e    state_q, state_d;
   logic [BITW-1:0] addr_q, addr_d;
   logic            phase_q, phase_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            fail_q, fail_d;
   logic [BITW-1:0] fail_addr_q, fail_addr_d;
   logic            cmp_valid_q, cmp_valid_d;
   logic            cmp_pol_q, cmp_pol_d;
   logic [BITW-1:0] cmp_addr_q, cmp_addr_d;

   march_op_t       op;
   logic            in_sweep;
   logic            last_op;
   logic            last_addr;
   logic            mismatch;

   // Array request for this cycle follows directly from the registered sequencer position
   always_comb begin
      op        = elem_op(state_q, phase_q);
      in_sweep  = (elem_len(state_q) != 2'd0);
      arr_en    = in_sweep;
      arr_we    = in_sweep && (op.kind == OP_WR);
      arr_addr  = addr_q;
      arr_wdata = {DATA_WIDTH{op.pol}};
   end

   // Next-state: element/address stepping, compare pipeline and first-fail abort
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      phase_d     = phase_q;
      busy_d      = busy_q;
      done_d      = done_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      cmp_valid_d = 1'b0;
      cmp_pol_d   = cmp_pol_q;
      cmp_addr_d  = cmp_addr_q;

      last_op   = (elem_len(state_q) == 2'd1) || phase_q;
      last_addr = (elem_dir(state_q) == DIR_DOWN) ? (addr_q == '0) : (addr_q == LAST_ADDR);
      mismatch  = cmp_valid_q && (rd_data != {DATA_WIDTH{cmp_pol_q}});

      case (state_q)
         IDLE: begin
            if (bist_start) begin
               state_d     = M0;
               addr_d      = '0;
               phase_d     = 1'b0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
            end
         end
         FLUSH, DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            if (op.kind == OP_RD) begin
               cmp_valid_d = 1'b1;
               cmp_pol_d   = op.pol;
               cmp_addr_d  = addr_q;
            end
            if (last_op) begin
               phase_d = 1'b0;
               if (last_addr) begin
                  // Counters wrap only here, between elements
                  state_d = elem_next(state_q);
                  addr_d  = (elem_dir(elem_next(state_q)) == DIR_DOWN) ? LAST_ADDR : '0;
               end else begin
                  addr_d = (elem_dir(state_q) == DIR_DOWN) ? addr_q - 1'b1 : addr_q + 1'b1;
               end
            end else begin
               phase_d = 1'b1;
            end
         end
      endcase

      // First mismatch wins; a pending compare can still resolve in FLUSH
      if (mismatch && !fail_q && (state_q != IDLE) && (state_q != DONE)) begin
         fail_d      = 1'b1;
         fail_addr_d = cmp_addr_q;
         state_d     = DONE;
         busy_d      = 1'b1;
         done_d      = 1'b0;
      end
   end

   // Sequencer registers with registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         phase_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         cmp_valid_q <= 1'b0;
         cmp_pol_q   <= 1'b0;
         cmp_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         phase_q     <= phase_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         cmp_valid_q <= cmp_valid_d;
         cmp_pol_q   <= cmp_pol_d;
         cmp_addr_q  <= cmp_addr_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;

endmodule
`endif

// File: rtl/sram_bist_march.sv
// Single-port synchronous SRAM with byte-lane writes, held read data and an
// optional March C- self-test engine (compiled in when SRAM_BIST_EN is
// defined; otherwise the BIST ports are inert).
module sram_bist_march
   import sram_pkg::*;
#(
   parameter int MEM_DEPTH  = 8192,
   parameter int DATA_WIDTH = 32,
   parameter int BITW       = $clog2(MEM_DEPTH),
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  csn,
   input  logic                  we,
   input  logic [BE_WIDTH-1:0]   be,
   input  logic [BITW-1:0]       addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   input  logic                  bist_start,
   output logic                  bist_busy,
   output logic                  bist_done,
   output logic                  bist_fail,
   output logic [BITW-1:0]       bist_fail_addr
);

   // Depth need not be a power of two, so the top of the address space may be unmapped
   localparam logic [BITW:0] DEPTH_LIM = (BITW + 1)'(MEM_DEPTH);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  busy;
   logic                  func_en;
   logic                  in_range;
   logic                  wr_en;
   logic [BE_WIDTH-1:0]   wr_be;
   logic [BITW-1:0]       wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;

`ifdef SRAM_BIST_EN
   logic                  bist_arr_en;
   logic                  bist_arr_we;
   logic [BITW-1:0]       bist_arr_addr;
   logic [DATA_WIDTH-1:0] bist_arr_wdata;
   logic [DATA_WIDTH-1:0] bist_rd_q, bist_rd_d;

   sram_march_fsm #(
      .MEM_DEPTH  (MEM_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BITW       (BITW)
   ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .bist_start (bist_start),
      .rd_data    (bist_rd_q),
      .arr_en     (bist_arr_en),
      .arr_we     (bist_arr_we),
      .arr_addr   (bist_arr_addr),
      .arr_wdata  (bist_arr_wdata),
      .busy       (busy),
      .done       (bist_done),
      .fail       (bist_fail),
      .fail_addr  (bist_fail_addr)
   );

   // Self-test read path kept separate so dout holds its pre-test value
   always_comb begin
      bist_rd_d = bist_rd_q;
      if (bist_arr_en && !bist_arr_we) begin
         bist_rd_d = mem[bist_arr_addr];
      end
   end

   // Self-test read register; only consumed when a compare is pending
   always_ff @(posedge clk) begin
      bist_rd_q <= bist_rd_d;
   end
`else
   logic unused_bist_start;

   assign unused_bist_start = bist_start;
   assign busy              = 1'b0;
   assign bist_done         = 1'b0;
   assign bist_fail         = 1'b0;
   assign bist_fail_addr    = '0;
`endif

   assign bist_busy = busy;
   assign func_en   = !csn && !busy;
   assign in_range  = ({1'b0, addr} < DEPTH_LIM);

   // Write-port mux: self-test owns the array while busy, else the functional port
   always_comb begin
      wr_en   = func_en && we && in_range;
      wr_be   = be;
      wr_addr = addr;
      wr_data = din;
`ifdef SRAM_BIST_EN
      if (bist_arr_en) begin
         wr_en   = bist_arr_we;
         wr_be   = '1;
         wr_addr = bist_arr_addr;
         wr_data = bist_arr_wdata;
      end
`endif
   end

   // Array write with per-lane enables; contents are never reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (wr_be[i]) begin
               mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
         end
      end
   end

   // Read data updates only on a functional read; unmapped addresses read as zero
   always_comb begin
      dout_d = dout_q;
      if (func_en && !we) begin
         dout_d = in_range ? mem[addr] : '0;
      end
   end

   // Output data register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_sram_bist_march.sv
// Scoreboard bench for sram_bist_march: every stimulus cycle pushes the
// expected outputs (from a behavioural model) and a negedge monitor pops
// and compares. BIST scenarios are exercised when SRAM_BIST_EN is defined.
module tb_sram_bist_march;

   localparam int DEPTH = 12;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int BEW   = 4;

   logic          clk;
   logic          rst_n;
   logic          csn;
   logic          we;
   logic [BEW-1:0] be;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          bist_start;
   logic          bist_busy;
   logic          bist_done;
   logic          bist_fail;
   logic [AW-1:0] bist_fail_addr;

   sram_bist_march #(
      .MEM_DEPTH  (DEPTH),
      .DATA_WIDTH (DW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .csn            (csn),
      .we             (we),
      .be             (be),
      .addr           (addr),
      .din            (din),
      .dout           (dout),
      .bist_start     (bist_start),
      .bist_busy      (bist_busy),
      .bist_done      (bist_done),
      .bist_fail      (bist_fail),
      .bist_fail_addr (bist_fail_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] dout;
      logic          busy;
      logic          done;
      logic          fail;
      logic [AW-1:0] faddr;
      string         tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   logic [DW-1:0]  mm [DEPTH];
   logic [BEW-1:0] mv [DEPTH];
   logic [DW-1:0]  m_dout;
   bit             m_busy, m_done, m_fail;
   logic [AW-1:0]  m_faddr;

`ifdef SRAM_BIST_EN
   typedef struct {
      int a;
      bit rd;
      bit pol;
   } mop_t;

   mop_t ops[$];
   bit   pend_v;
   bit   pend_bad;
   int   pend_a;
   int   k;
   int   done_at;

   // March C- as a flat list of (address, op, background)
   task automatic build_ops();
      ops.delete();
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < DEPTH; i++) begin
            automatic int a = (e < 3) ? i : DEPTH - 1 - i;
            case (e)
               0: ops.push_back('{a: a, rd: 1'b0, pol: 1'b0});
               1, 3: begin
                  ops.push_back('{a: a, rd: 1'b1, pol: 1'b0});
                  ops.push_back('{a: a, rd: 1'b0, pol: 1'b1});
               end
               2, 4: begin
                  ops.push_back('{a: a, rd: 1'b1, pol: 1'b1});
                  ops.push_back('{a: a, rd: 1'b0, pol: 1'b0});
               end
               default: ops.push_back('{a: a, rd: 1'b1, pol: 1'b0});
            endcase
         end
      end
   endtask

   // One clock edge of a self-test run
   task automatic bist_edge();
      automatic bit   abort = 1'b0;
      automatic mop_t o;
      k++;
      if (pend_v && pend_bad && !m_fail) begin
         m_fail  = 1'b1;
         m_faddr = AW'(pend_a);
         done_at = k + 1;
         abort   = 1'b1;
      end
      pend_v = 1'b0;
      if (done_at == k) begin
         m_busy = 1'b0;
         m_done = 1'b1;
         return;
      end
      if (ops.size() > 0) begin
         o = ops.pop_front();
         if (o.rd) begin
            pend_v   = 1'b1;
            pend_a   = o.a;
            pend_bad = (mm[o.a] !== {DW{o.pol}});
         end else begin
            mm[o.a] = {DW{o.pol}};
            mv[o.a] = '1;
         end
         if (abort) ops.delete();
         else if (ops.size() == 0) done_at = k + 1;
      end
   endtask
`endif

   task automatic model_edge(input bit r, input bit c, input bit w, input logic [BEW-1:0] b,
                             input logic [AW-1:0] a, input logic [DW-1:0] d, input bit st);
      automatic bit was_busy;
      if (!r) begin
         m_dout  = '0;
         m_busy  = 1'b0;
         m_done  = 1'b0;
         m_fail  = 1'b0;
         m_faddr = '0;
         foreach (mv[i]) mv[i] = '0;
`ifdef SRAM_BIST_EN
         ops.delete();
         pend_v = 1'b0;
`endif
         return;
      end
      was_busy = m_busy;
`ifdef SRAM_BIST_EN
      if (was_busy) bist_edge();
`endif
      if (!was_busy && !c) begin
         if (w) begin
            if (int'(a) < DEPTH) begin
               for (int l = 0; l < BEW; l++) begin
                  if (b[l]) begin
                     mm[a][8*l +: 8] = d[8*l +: 8];
                     mv[a][l] = 1'b1;
                  end
               end
            end
         end else begin
            m_dout = (int'(a) < DEPTH) ? mm[a] : '0;
         end
      end
`ifdef SRAM_BIST_EN
      if (!was_busy && st) begin
         m_busy  = 1'b1;
         m_done  = 1'b0;
         m_fail  = 1'b0;
         m_faddr = '0;
         k       = 0;
         done_at = -1;
         pend_v  = 1'b0;
         build_ops();
      end
`endif
   endtask

   function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endfunction

   // Monitor: compare the expectation pushed for the previous edge
   exp_t me;
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         me = sb.pop_front();
         chk({me.tag, ".dout"}, dout, me.dout);
         chk({me.tag, ".busy"}, DW'(bist_busy), DW'(me.busy));
         chk({me.tag, ".done"}, DW'(bist_done), DW'(me.done));
         chk({me.tag, ".fail"}, DW'(bist_fail), DW'(me.fail));
         chk({me.tag, ".fail_addr"}, DW'(bist_fail_addr), DW'(me.faddr));
      end
   end

   task automatic cyc(input bit r, input bit c, input bit w, input logic [BEW-1:0] b,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input bit st, input string tag);
      exp_t e;
      rst_n      = r;
      csn        = c;
      we         = w;
      be         = b;
      addr       = a;
      din        = d;
      bist_start = st;
      @(posedge clk);
      model_edge(r, c, w, b, a, d, st);
      e.dout  = m_dout;
      e.busy  = m_busy;
      e.done  = m_done;
      e.fail  = m_fail;
      e.faddr = m_faddr;
      e.tag   = tag;
      sb.push_back(e);
      $display("cycle %-12s rst_n=%0b csn=%0b we=%0b be=%h addr=%0d din=%h start=%0b",
               tag, r, c, w, b, a, d, st);
      @(negedge clk);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] b, input string tag);
      cyc(1'b1, 1'b0, 1'b1, b, a, d, 1'b0, tag);
   endtask

   task automatic rd(input logic [AW-1:0] a, input string tag);
      cyc(1'b1, 1'b0, 1'b0, BEW'($urandom), a, $urandom, 1'b0, tag);
   endtask

   task automatic idle(input string tag);
      cyc(1'b1, 1'b1, 1'($urandom), BEW'($urandom), AW'($urandom), $urandom, 1'b0, tag);
   endtask

   task automatic rst_cyc(input string tag);
      cyc(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0, tag);
   endtask

   // Random functional traffic; reads target only fully written or unmapped words
   task automatic rand_cycle(input string tag);
      automatic int            sel = $urandom_range(0, 9);
      automatic logic [AW-1:0] a   = AW'($urandom_range(0, 15));
      if (sel < 4) begin
         wr(a, $urandom, BEW'($urandom), tag);
      end else if (sel < 8) begin
         if (int'(a) < DEPTH && mv[a] != 4'hf) wr(a, $urandom, 4'hf, tag);
         else rd(a, tag);
      end else begin
         idle(tag);
      end
   endtask

`ifdef SRAM_BIST_EN
   task automatic junk_cycle(input string tag);
      cyc(1'b1, 1'($urandom), 1'($urandom), BEW'($urandom), AW'($urandom), $urandom,
          ($urandom_range(0, 7) == 0), tag);
   endtask
`endif

   initial begin
      rst_n      = 1'b0;
      csn        = 1'b1;
      we         = 1'b0;
      be         = '0;
      addr       = '0;
      din        = '0;
      bist_start = 1'b0;
      m_dout     = '0;
      m_busy     = 1'b0;
      m_done     = 1'b0;
      m_fail     = 1'b0;
      m_faddr    = '0;
      foreach (mv[i]) mv[i] = '0;
      @(negedge clk);
      repeat (3) rst_cyc("reset");

      // Byte-lane merge
      wr(4'd5, 32'hAABBCCDD, 4'b1111, "wr_full");
      wr(4'd5, 32'h11223344, 4'b0101, "wr_lanes");
      rd(4'd5, "be_merge");

      // Read then hold with chip deselected
      wr(4'd3, 32'h5A5A5A5A, 4'b1111, "wr3");
      rd(4'd3, "rd3");
      repeat (4) idle("csn_hold");
      rst_cyc("reset_hold");
      idle("post_reset");

      // Unmapped addresses: write dropped, read returns zero
      wr(4'd0, 32'h0BADF00D, 4'b1111, "wr0");
      rd(4'd0, "rd0");
      wr(4'd13, 32'hDEADBEEF, 4'b1111, "wr_oor");
      rd(4'd13, "rd_oor");
      rd(4'd15, "rd_oor_top");
      rd(4'd11, "rd_last_pre");
      wr(4'd11, 32'h12345678, 4'b1111, "wr_last");
      rd(4'd11, "rd_last");

      for (int i = 0; i < DEPTH; i++) wr(AW'(i), $urandom, 4'hf, "init");
      for (int i = 0; i < 300; i++) rand_cycle("random");

`ifdef SRAM_BIST_EN
      // Passing run with ignored functional traffic and repeated start pulses
      cyc(1'b1, 1'b0, 1'b1, 4'hf, 4'd2, 32'hCAFEF00D, 1'b1, "bist_start");
      for (int i = 0; i < 400 && m_busy; i++) junk_cycle("bist_run");
      idle("bist_end");
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), "post_bist");

      // Failing run: corrupt a word after the w0 sweep
      cyc(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1, "fail_start");
      for (int i = 0; i < 400 && m_busy; i++) begin
         if (k == 20) begin
            dut.mem[9] = 32'h0000_0001;
            mm[9]      = 32'h0000_0001;
         end
         idle("fail_run");
      end
      idle("fail_end");

      // Reset in the middle of a run, then a clean run
      cyc(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1, "rst_start");
      for (int i = 0; i < 400 && m_busy && k < 49; i++) idle("rst_run");
      rst_cyc("mid_reset");
      rst_cyc("mid_reset");
      idle("after_reset");
      cyc(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b1, "rerun_start");
      for (int i = 0; i < 400 && m_busy; i++) idle("rerun");
      idle("rerun_end");
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), "post_rerun");
`else
      // Start pulse is inert; same-cycle functional access proceeds
      cyc(1'b1, 1'b0, 1'b1, 4'hf, 4'd2, 32'hCAFEF00D, 1'b1, "nobist_start");
      rd(4'd2, "nobist_rd");
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 1'b0, '0, AW'(i % DEPTH), '0, 1'($urandom), "nobist_mix");
      end
`endif

      repeat (2) idle("drain");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_bist_march.md
# sram_bist_march

Parametrised single-port synchronous SRAM with per-byte write enables, a defined read-data hold, and an integrated March C- built-in self-test engine. It is the next generation of the team's SRAM macro model and sits behind the AHB-SRAM bridge, which drives the functional port. At power-up or on request, a BIST controller can sweep the whole array and report pass/fail plus the first failing address.

## Interface
Parameters:
- MEM_DEPTH, 8192, number of words; any value ≥ 2, power of two not required
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- BITW, $clog2(MEM_DEPTH), address width
- BE_WIDTH, DATA_WIDTH/8, number of byte lanes

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- csn  in  1  chip select, active-low
- we  in  1  write enable, active-high; 0 = read
- be  in  BE_WIDTH  byte-lane write enables; be[i] covers din[8i+7:8i]
- addr  in  BITW  word address
- din  in  DATA_WIDTH  write data
- dout  out  DATA_WIDTH  registered read data
- bist_start  in  1  single-cycle request to run the self-test
- bist_busy  out  1  high while the self-test owns the array
- bist_done  out  1  sticky; high once a run has finished
- bist_fail  out  1  sticky; high if the last run found a mismatch
- bist_fail_addr  out  BITW  address of the first mismatch

## Operation
- Array: exactly MEM_DEPTH words. Reset does not clear the array. Contents are undefined after power-up.
- Functional write (csn=0, we=1, bist_busy=0): at the clock edge, each lane with be[i]=1 is updated and other lanes keep their value. dout holds.
- Functional read (csn=0, we=0, bist_busy=0): dout takes mem[addr] at the clock edge. be is ignored.
- An addr ≥ MEM_DEPTH on a write is dropped. The same address on a read returns 0.
- csn=1: no access, and dout holds its last value (never X).
- BIST request: bist_start is sampled at an edge where bist_busy=0. That edge sets bist_busy=1 and clears bist_done, bist_fail and bist_fail_addr. A bist_start seen while busy is ignored.
- BIST states: IDLE, M0 (ascending w0), M1 (ascending r0,w1), M2 (ascending r1,w0), M3 (descending r0,w1), M4 (descending r1,w0), M5 (descending r0), FLUSH, DONE→IDLE.
- Each read or write takes one cycle. Within an element, each address runs its ops in the listed order before the address steps. Data backgrounds are all-0 and all-1.
- Compare: read data registered at edge E is compared against the expected value and the result is registered at edge E+1.
- On the first mismatch: bist_fail=1 and bist_fail_addr=failing address. The sequencer then aborts straight to DONE and skips FLUSH.
- While busy: csn, we, be, addr and din are ignored, and dout holds its pre-BIST value.
- On a passing run the array is left all-zero.

## Timing
- Reset values: dout=0, bist_busy=0, bist_done=0, bist_fail=0, bist_fail_addr=0. The FSM resets to IDLE.
- Functional read latency is 1 cycle. Back-to-back accesses run at full rate.
- A write followed by a read to the same address on the next cycle returns the new data.
- BIST duration, with start sampled at edge 0:
  - ops occupy edges 1..10·MEM_DEPTH
  - FLUSH is at edge 10·MEM_DEPTH+1
  - at that edge bist_busy falls and bist_done rises together
- On a failure whose read is at edge E: bist_fail rises at E+1, and bist_busy falls with bist_done rising at E+2.
- Reset asserted mid-run aborts immediately. All outputs return to their reset values and the array contents are undefined.
- Address counters wrap only between elements. The descending sweep starts at MEM_DEPTH-1 and ends at 0.

## Configuration
- SRAM_BIST_EN defined: the BIST engine is compiled in as described above.
- SRAM_BIST_EN undefined: no sequencer or compare logic is built, and the ports still exist.
  - bist_busy, bist_done and bist_fail are tied to 0, and bist_fail_addr is tied to 0.
  - bist_start is ignored.
  - The functional port is always active.

## Structure
- Package sram_pkg holds:
  - the March state enum (IDLE, M0–M5, FLUSH, DONE)
  - the op encoding (RD, WR) with expected/write data polarity
  - the per-element op-count and direction constants
- Sub-module sram_march_fsm contains the sequencer, address counter, compare and fail capture. It drives the array-side mux.
- The top level holds the array, the byte-lane write logic and the dout register.

## Test plan
- Write with DATA_WIDTH=32: write 0xAABBCCDD to addr 5 with be=4'b1111, then write 0x11223344 to addr 5 with be=4'b0101, then read addr 5 → dout=0xAA22CC44 one cycle after the read edge.
- Read addr 3 (holding 0x5A5A5A5A), then hold csn=1 for 4 cycles → dout stays 0x5A5A5A5A. After reset, dout=0.
- BIST pass with MEM_DEPTH=16: pulse bist_start at edge 0 → bist_busy is high for edges 1–160, bist_done=1 and bist_fail=0 at edge 161, and every address reads 0 afterwards.
- BIST fail with MEM_DEPTH=16: force mem[9] bit 0 stuck-at-1 → bist_fail=1 and bist_fail_addr=9 (detected in M1 r0), and bist_done rises one edge later.
- Assert rst_n low at edge 50 of a run → all outputs return to 0 and the FSM is IDLE. A new bist_start then completes normally.
- Build without SRAM_BIST_EN and pulse bist_start → bist_busy, bist_done and bist_fail stay 0, and a functional write/read issued the same cycle works.
